// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared loader states and stream-format constants
package imem_boot_loader_pkg;

  localparam int unsigned DEF_IMEM_WORDS = 256;
  localparam int unsigned DEF_DMEM_BYTES = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    HDR_I,
    INSTR,
    HDR_D,
    DATA,
    DONE,
    ERR
  } state_e;

  // Headers are range-checked on the full 32-bit value so a huge count never aliases to a small one.
  function automatic logic hdr_too_big(input logic [31:0] hdr, input int unsigned max_words);
    return hdr > max_words;
  endfunction

endpackage

// File: rtl/imem_boot_loader_assembler.sv
// rtl/imem_boot_loader_assembler.sv - gathers little-endian bytes into 32-bit words
module byte_to_word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] buf_q, buf_d;

  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (byte_valid_i) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    buf_d[7:0]   = byte_i;
        2'd1:    buf_d[15:8]  = byte_i;
        2'd2:    buf_d[23:16] = byte_i;
        default: buf_d        = buf_q;
      endcase
    end
  end

  // The fourth byte is not stored; the word is presented combinationally with it.
  assign word_o      = {byte_i, buf_q};
  assign word_done_o = byte_valid_i && (cnt_q == 2'd3);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= 2'd0;
      buf_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams program and data into CPU memories, then releases start
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = DEF_IMEM_WORDS,
  parameter int unsigned DMEM_BYTES = DEF_DMEM_BYTES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        imem_we_o,
  output logic [7:0]  imem_addr_o,
  output logic [31:0] imem_data_o,
  output logic        dmem_we_o,
  output logic [4:0]  dmem_addr_o,
  output logic [31:0] dmem_data_o,
  output logic        start_o,
  output logic        error_o
);

  localparam int unsigned DMEM_WORDS = DMEM_BYTES / BYTES_PER_WORD;

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [8:0]  last_q, last_d;
  logic        imem_we_q, imem_we_d;
  logic [7:0]  imem_addr_q, imem_addr_d;
  logic [31:0] imem_data_q, imem_data_d;
  logic        dmem_we_q, dmem_we_d;
  logic [4:0]  dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_data_q, dmem_data_d;
  logic        start_q, start_d;

  logic        byte_acc;
  logic [31:0] word;
  logic        word_done;

  assign rx_ready_o = (state_q == HDR_I) || (state_q == INSTR) ||
                      (state_q == HDR_D) || (state_q == DATA);
  assign byte_acc   = rx_valid_i && rx_ready_o;

  byte_to_word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_i       (rx_data_i),
    .byte_valid_i (byte_acc),
    .word_o       (word),
    .word_done_o  (word_done)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    dmem_we_d   = 1'b0;
    dmem_addr_d = dmem_addr_q;
    dmem_data_d = dmem_data_q;
    if (word_done) begin
      case (state_q)
        HDR_I: begin
          cnt_d  = 9'd0;
          last_d = word[8:0] - 9'd1;
          if (hdr_too_big(word, IMEM_WORDS)) state_d = ERR;
          else if (word == 32'd0)            state_d = HDR_D;
          else                               state_d = INSTR;
        end
        INSTR: begin
          imem_we_d   = 1'b1;
          imem_addr_d = cnt_q[7:0];
          imem_data_d = word;
          cnt_d       = cnt_q + 9'd1;
          if (cnt_q == last_q) state_d = HDR_D;
        end
        HDR_D: begin
          cnt_d  = 9'd0;
          last_d = word[8:0] - 9'd1;
          if (hdr_too_big(word, DMEM_WORDS)) state_d = ERR;
          else if (word == 32'd0)            state_d = DONE;
          else                               state_d = DATA;
        end
        DATA: begin
          dmem_we_d   = 1'b1;
          dmem_addr_d = {cnt_q[2:0], 2'b00};
          dmem_data_d = word;
          cnt_d       = cnt_q + 9'd1;
          if (cnt_q == last_q) state_d = DONE;
        end
        default: state_d = state_q;
      endcase
    end
    // Hold start back one cycle behind the final data write so memory settles before the CPU runs.
    start_d = (state_q == DONE) || ((state_d == DONE) && !dmem_we_d);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= HDR_I;
      cnt_q       <= 9'd0;
      last_q      <= 9'd0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= 8'd0;
      imem_data_q <= 32'd0;
      dmem_we_q   <= 1'b0;
      dmem_addr_q <= 5'd0;
      dmem_data_q <= 32'd0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      dmem_we_q   <= dmem_we_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_data_q <= dmem_data_d;
      start_q     <= start_d;
    end
  end

  assign imem_we_o   = imem_we_q;
  assign imem_addr_o = imem_addr_q;
  assign imem_data_o = imem_data_q;
  assign dmem_we_o   = dmem_we_q;
  assign dmem_addr_o = dmem_addr_q;
  assign dmem_data_o = dmem_data_q;
  assign start_o     = start_q;
  assign error_o     = (state_q == ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [7:0]  rx_data_i = 8'd0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic        imem_we_o;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_data_o;
  logic        dmem_we_o;
  logic [4:0]  dmem_addr_o;
  logic [31:0] dmem_data_o;
  logic        start_o;
  logic        error_o;

  int errors = 0;
  int checks = 0;

  imem_boot_loader dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .imem_we_o   (imem_we_o),
    .imem_addr_o (imem_addr_o),
    .imem_data_o (imem_data_o),
    .dmem_we_o   (dmem_we_o),
    .dmem_addr_o (dmem_addr_o),
    .dmem_data_o (dmem_data_o),
    .start_o     (start_o),
    .error_o     (error_o)
  );

  always #5 clk = ~clk;

  logic [31:0] imem_img [256];
  logic [31:0] dmem_img [8];
  logic [31:0] stream_q [$];
  logic        mon_clr = 1'b1;
  int cyc = 0;
  int icnt, dcnt, overlap, misalign, start_cyc, last_d_cyc;
  int last_iaddr, last_daddr;

  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      icnt = 0; dcnt = 0; overlap = 0; misalign = 0;
      start_cyc = -1; last_d_cyc = -1; last_iaddr = -1; last_daddr = -1;
      for (int i = 0; i < 256; i++) imem_img[i] = 32'd0;
      for (int i = 0; i < 8; i++) dmem_img[i] = 32'd0;
    end else begin
      if (imem_we_o && dmem_we_o) overlap++;
      if (imem_we_o) begin
        imem_img[imem_addr_o] = imem_data_o;
        icnt++;
        last_iaddr = int'(imem_addr_o);
      end
      if (dmem_we_o) begin
        if (dmem_addr_o[1:0] != 2'b00) misalign++;
        dmem_img[dmem_addr_o[4:2]] = dmem_data_o;
        dcnt++;
        last_daddr = int'(dmem_addr_o);
        last_d_cyc = cyc;
      end
      if (start_o && start_cyc < 0) start_cyc = cyc;
    end
  end

  task automatic idle(input int n);
    rx_valid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rx_valid_i = 1'b0;
    rst_i = 1'b0;
    mon_clr = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_i = 1'b1;
    @(negedge clk); #1;
    mon_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    logic acc;
    if (gap > 0) idle(gap);
    rx_data_i = b;
    rx_valid_i = 1'b1;
    t = 0;
    do begin
      acc = rx_ready_o;
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 20);
    if (!acc) begin
      errors++; checks++;
      $display("FAIL send_byte timeout: rx_ready_o=%0b required 1", rx_ready_o);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_stream(input int gap);
    foreach (stream_q[i]) send_word(stream_q[i], gap);
    rx_valid_i = 1'b0;
  endtask

  task automatic check_start_after_dmem(input string name);
    checks++;
    if (start_cyc !== last_d_cyc + 1 || last_d_cyc < 0) begin
      errors++;
      $display("FAIL %s start timing: start cycle %0d required %0d", name, start_cyc, last_d_cyc + 1);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    mon_clr = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({imem_we_o, dmem_we_o, start_o, error_o} !== 4'b0000 ||
        imem_addr_o !== 8'd0 || dmem_addr_o !== 5'd0 ||
        imem_data_o !== 32'd0 || dmem_data_o !== 32'd0) begin
      errors++;
      $display("FAIL reset outputs: we=%b%b start=%b err=%b ia=%h da=%h id=%h dd=%h required all 0",
               imem_we_o, dmem_we_o, start_o, error_o, imem_addr_o, dmem_addr_o, imem_data_o, dmem_data_o);
    end
    do_reset();
    checks++;
    if (rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset ready: rx_ready_o=%b required 1", rx_ready_o);
    end
  endtask

  task automatic run_basic(input string name, input int gap);
    do_reset();
    stream_q = '{32'd2, 32'h2008_0005, 32'h0000_0000, 32'd1, 32'h0000_0005};
    imem_img[1] = 32'hFFFF_FFFF;
    send_stream(gap);
    idle(4);
    checks++;
    if (imem_img[0] !== 32'h2008_0005 || imem_img[1] !== 32'h0000_0000) begin
      errors++;
      $display("FAIL %s imem: %h %h required 20080005 00000000", name, imem_img[0], imem_img[1]);
    end
    checks++;
    if (dmem_img[0] !== 32'h0000_0005) begin
      errors++;
      $display("FAIL %s dmem: %h required 00000005", name, dmem_img[0]);
    end
    checks++;
    if (icnt !== 2 || dcnt !== 1 || overlap !== 0) begin
      errors++;
      $display("FAIL %s strobes: imem=%0d dmem=%0d overlap=%0d required 2 1 0", name, icnt, dcnt, overlap);
    end
    check_start_after_dmem(name);
    checks++;
    if (start_o !== 1'b1 || rx_ready_o !== 1'b0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL %s final: start=%b ready=%b err=%b required 1 0 0", name, start_o, rx_ready_o, error_o);
    end
  endtask

  task automatic test_back_to_back();
    run_basic("back_to_back", 0);
  endtask

  task automatic test_sparse_valid();
    run_basic("sparse_valid", 2);
  endtask

  task automatic test_empty();
    do_reset();
    send_word(32'd0, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if (start_o !== 1'b0) begin
      errors++;
      $display("FAIL empty early start: start_o=%b required 0", start_o);
    end
    send_byte(8'h00, 0);
    rx_valid_i = 1'b0;
    checks++;
    if (start_o !== 1'b1) begin
      errors++;
      $display("FAIL empty start: start_o=%b required 1", start_o);
    end
    idle(4);
    checks++;
    if (icnt !== 0 || dcnt !== 0) begin
      errors++;
      $display("FAIL empty strobes: imem=%0d dmem=%0d required 0 0", icnt, dcnt);
    end
  endtask

  task automatic test_hdr_error();
    do_reset();
    send_word(32'd257, 0);
    rx_valid_i = 1'b0;
    checks++;
    if (error_o !== 1'b1 || rx_ready_o !== 1'b0 || start_o !== 1'b0) begin
      errors++;
      $display("FAIL hdr_error state: err=%b ready=%b start=%b required 1 0 0", error_o, rx_ready_o, start_o);
    end
    rx_valid_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rx_data_i = 8'(i * 17 + 3);
      @(posedge clk); #1;
    end
    idle(4);
    checks++;
    if (icnt !== 0 || dcnt !== 0 || start_o !== 1'b0 || error_o !== 1'b1) begin
      errors++;
      $display("FAIL hdr_error after bytes: imem=%0d dmem=%0d start=%b err=%b required 0 0 0 1",
               icnt, dcnt, start_o, error_o);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_word(32'd4, 0);
    send_word(32'hDEAD_0001, 0);
    send_word(32'hDEAD_0002, 0);
    idle(1);
    rst_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (start_o !== 1'b0 || imem_we_o !== 1'b0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset outputs: start=%b we=%b err=%b required 0 0 0", start_o, imem_we_o, error_o);
    end
    do_reset();
    checks++;
    if (rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset ready: rx_ready_o=%b required 1", rx_ready_o);
    end
    stream_q = '{32'd4, 32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003,
                 32'd2, 32'hAAAA_5555, 32'h0102_0304};
    send_stream(0);
    idle(4);
    checks++;
    if (imem_img[0] !== 32'h1111_0000 || imem_img[1] !== 32'h2222_0001 ||
        imem_img[2] !== 32'h3333_0002 || imem_img[3] !== 32'h4444_0003) begin
      errors++;
      $display("FAIL mid_reset imem: %h %h %h %h required 11110000 22220001 33330002 44440003",
               imem_img[0], imem_img[1], imem_img[2], imem_img[3]);
    end
    checks++;
    if (dmem_img[0] !== 32'hAAAA_5555 || dmem_img[1] !== 32'h0102_0304 || icnt !== 4 || dcnt !== 2) begin
      errors++;
      $display("FAIL mid_reset dmem: %h %h cnt %0d/%0d required aaaa5555 01020304 cnt 4/2",
               dmem_img[0], dmem_img[1], icnt, dcnt);
    end
    check_start_after_dmem("mid_reset");
  endtask

  task automatic test_max_load();
    do_reset();
    stream_q = {};
    stream_q.push_back(32'd256);
    for (int i = 0; i < 256; i++) stream_q.push_back(32'hC0DE_0000 | 32'(i));
    stream_q.push_back(32'd8);
    for (int k = 0; k < 8; k++) stream_q.push_back(32'h1111_1111 * 32'(k + 1));
    send_stream(0);
    idle(4);
    checks++;
    if (icnt !== 256 || last_iaddr !== 255 || imem_img[0] !== 32'hC0DE_0000 || imem_img[255] !== 32'hC0DE_00FF) begin
      errors++;
      $display("FAIL max imem: cnt=%0d last=%0d w0=%h w255=%h required 256 255 c0de0000 c0de00ff",
               icnt, last_iaddr, imem_img[0], imem_img[255]);
    end
    checks++;
    if (dcnt !== 8 || last_daddr !== 28 || dmem_img[7] !== 32'h8888_8888 || misalign !== 0) begin
      errors++;
      $display("FAIL max dmem: cnt=%0d last=%0d w7=%h misalign=%0d required 8 28 88888888 0",
               dcnt, last_daddr, dmem_img[7], misalign);
    end
    checks++;
    if (overlap !== 0 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL max overlap/err: overlap=%0d err=%b required 0 0", overlap, error_o);
    end
    check_start_after_dmem("max_load");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_sparse_valid();
    test_empty();
    test_hdr_error();
    test_mid_reset();
    test_max_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
